// File: rtl/aes_pkg.sv
`default_nettype none
// ============================================================================
// Package  : aes_pkg
// Desc     : Shared AES widths, key-expander state encoding and the S-box
//            table used by every byte-substitution block.
// Revision : 1.0 - initial release
// ============================================================================
package aes_pkg;

  localparam int BYTE       = 8;
  localparam int WORD       = 32;
  localparam int SENTENCE   = 128;
  localparam int NUM_ROUNDS = 10;
  localparam int IDX_W      = 4;

  // Index of the final round key; the expander stops advancing here
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_ROUNDS);

  // Key-expander FSM encoding
  typedef logic [0:0] state_t;
  localparam state_t ST_IDLE = 1'b0;
  localparam state_t ST_EMIT = 1'b1;

  // Forward AES S-box, indexed by the input byte
  localparam logic [BYTE-1:0] SBOX [0:255] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

endpackage
`default_nettype wire

// File: rtl/aes_key_expander_if.sv
`default_nettype none
// ============================================================================
// Interface : aes_key_expander_if
// Desc      : Start/key request plus valid/ready round-key delivery between
//             the key expander (slave) and the round datapath (master).
// Revision  : 1.0 - initial release
// ============================================================================
interface aes_key_expander_if;
  import aes_pkg::*;

  logic                start;
  logic [SENTENCE-1:0] key_in;
  logic                key_ready;
  logic                key_valid;
  logic [SENTENCE-1:0] round_key;
  logic [IDX_W-1:0]    round_idx;
  logic                busy;
  logic                done;

  // Consumer side: requests expansions and accepts round keys
  modport master (
    output start, key_in, key_ready,
    input  key_valid, round_key, round_idx, busy, done
  );

  // Expander side
  modport slave (
    input  start, key_in, key_ready,
    output key_valid, round_key, round_idx, busy, done
  );

endinterface
`default_nettype wire

// File: rtl/rcon.sv
`default_nettype none
// ============================================================================
// Module   : rcon
// Desc     : AES round-constant lookup. Index n yields the constant used to
//            derive round key n+1, placed in the most significant byte.
// Revision : 1.0 - initial release
// ============================================================================
module rcon
  import aes_pkg::*;
(
  input  logic [IDX_W-1:0] round_i,
  output logic [WORD-1:0]  rcon_o
);

  // Table lookup; indices past 9 have no defined constant and return zero
  always_comb begin
    rcon_o = '0;
    case (round_i)
      4'd0:    rcon_o = {8'h01, 24'h0};
      4'd1:    rcon_o = {8'h02, 24'h0};
      4'd2:    rcon_o = {8'h04, 24'h0};
      4'd3:    rcon_o = {8'h08, 24'h0};
      4'd4:    rcon_o = {8'h10, 24'h0};
      4'd5:    rcon_o = {8'h20, 24'h0};
      4'd6:    rcon_o = {8'h40, 24'h0};
      4'd7:    rcon_o = {8'h80, 24'h0};
      4'd8:    rcon_o = {8'h1b, 24'h0};
      4'd9:    rcon_o = {8'h36, 24'h0};
      default: rcon_o = '0;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/sub_word.sv
`default_nettype none
// ============================================================================
// Module   : sub_word
// Desc     : Four parallel S-box lookups across a 32-bit word. Purely
//            combinational so it can sit inside single-cycle datapaths.
// Revision : 1.0 - initial release
// ============================================================================
module sub_word
  import aes_pkg::*;
(
  input  logic [WORD-1:0] word_i,
  output logic [WORD-1:0] word_o
);

  // One independent S-box per byte lane
  generate
    for (genvar g = 0; g < WORD / BYTE; g++) begin : g_sbox
      assign word_o[g*BYTE +: BYTE] = SBOX[word_i[g*BYTE +: BYTE]];
    end
  endgenerate

endmodule
`default_nettype wire

// File: rtl/aes_key_expander.sv
`default_nettype none
// ============================================================================
// Module   : aes_key_expander
// Desc     : Sequential AES-128 key schedule. Captures a cipher key on start
//            and hands out round keys 0..10 over valid/ready, computing the
//            next key in a single combinational step per accepted key.
// Revision : 1.0 - initial release
// ============================================================================
module aes_key_expander
  import aes_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  aes_key_expander_if.slave bus_if
);

  state_t              state_q, state_d;
  logic [SENTENCE-1:0] round_key_q, round_key_d;
  logic [IDX_W-1:0]    round_idx_q, round_idx_d;
  logic                done_q, done_d;

  logic                w_accept;
  logic                w_fire;
  logic                w_last;
  logic [WORD-1:0]     w_w0, w_w1, w_w2, w_w3;
  logic [WORD-1:0]     w_rot, w_sub, w_rcon, w_t;
  logic [WORD-1:0]     w_n0, w_n1, w_n2, w_n3;
  logic [SENTENCE-1:0] w_next_key;

  assign w_accept = (state_q == ST_IDLE) && bus_if.start;
  assign w_fire   = (state_q == ST_EMIT) && bus_if.key_ready;
  assign w_last   = (round_idx_q == LAST_IDX);

  // Next-key datapath. At index 10 the Rcon output is undefined, but the
  // result is never loaded because the last handshake returns to IDLE.
  assign w_w0  = round_key_q[127:96];
  assign w_w1  = round_key_q[95:64];
  assign w_w2  = round_key_q[63:32];
  assign w_w3  = round_key_q[31:0];
  assign w_rot = {w_w3[23:0], w_w3[31:24]};

  rcon u_rcon (
    .round_i (round_idx_q),
    .rcon_o  (w_rcon)
  );

  sub_word u_sub_word (
    .word_i (w_rot),
    .word_o (w_sub)
  );

  assign w_t        = w_sub ^ w_rcon;
  assign w_n0       = w_w0 ^ w_t;
  assign w_n1       = w_w1 ^ w_n0;
  assign w_n2       = w_w2 ^ w_n1;
  assign w_n3       = w_w3 ^ w_n2;
  assign w_next_key = {w_n0, w_n1, w_n2, w_n3};

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // FSM next state: start only matters in IDLE, last accepted key ends EMIT
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (bus_if.start)     state_d = ST_EMIT;
      ST_EMIT: if (w_fire && w_last) state_d = ST_IDLE;
      default:                       state_d = ST_IDLE;
    endcase
  end

  // FSM outputs: valid/busy follow the state, data comes straight from registers
  always_comb begin
    bus_if.key_valid = (state_q == ST_EMIT);
    bus_if.busy      = (state_q == ST_EMIT);
    bus_if.done      = done_q;
    bus_if.round_key = round_key_q;
    bus_if.round_idx = round_idx_q;
  end

  // Key/index/done next values: load on accept, advance on handshake, hold on stall
  always_comb begin
    round_key_d = round_key_q;
    round_idx_d = round_idx_q;
    done_d      = 1'b0;
    if (w_accept) begin
      round_key_d = bus_if.key_in;
      round_idx_d = '0;
    end else if (w_fire) begin
      if (w_last) begin
        done_d = 1'b1;
      end else begin
        round_key_d = w_next_key;
        round_idx_d = round_idx_q + 4'd1;
      end
    end
  end

  // Datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      round_key_q <= '0;
      round_idx_q <= '0;
      done_q      <= 1'b0;
    end else begin
      round_key_q <= round_key_d;
      round_idx_q <= round_idx_d;
      done_q      <= done_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_aes_key_expander.sv
`default_nettype none
// ============================================================================
// Module   : tb_aes_key_expander
// Desc     : Scoreboard bench for aes_key_expander. Expected round keys come
//            from a word-array key schedule with an S-box derived from the
//            GF(2^8) inverse and affine map.
// Revision : 1.0 - initial release
// ============================================================================
module tb_aes_key_expander;
  import aes_pkg::*;

  localparam logic [127:0] C_FIPS_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] C_FIPS_K1   = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] C_FIPS_K10  = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] C_SEQ_KEY   = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C_SEQ_K1    = 128'hd6aa74fdd2af72fadaa678f1d6ab76fe;
  localparam logic [127:0] C_SEQ_K10   = 128'h13111d7fe3944a17f307a78b4d2b30c5;
  localparam logic [127:0] C_ZERO_K1   = 128'h62636363626363636263636362636363;

  typedef struct packed {
    logic [3:0]   idx;
    logic [127:0] key;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  aes_key_expander_if bus();

  aes_key_expander dut (
    .clk    (clk),
    .rst    (rst),
    .bus_if (bus)
  );

  exp_t       sb_q[$];
  logic [7:0] sb_tab [0:255];
  int         n_tests = 0;
  int         n_fail  = 0;
  bit         ready_rand = 1'b0;
  bit         done_pend  = 1'b0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [7:0] xtime(input logic [7:0] a);
    return a[7] ? ({a[6:0], 1'b0} ^ 8'h1b) : {a[6:0], 1'b0};
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= x;
      x = xtime(x);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
    logic [15:0] d;
    d = {v, v} << n;
    return d[15:8];
  endfunction

  task automatic build_sbox();
    for (int b = 0; b < 256; b++) begin
      logic [7:0] inv;
      inv = 8'h00;
      for (int v = 1; v < 256; v++)
        if (b != 0 && gmul(8'(b), 8'(v)) == 8'h01) inv = 8'(v);
      sb_tab[b] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  task automatic push_expected(input logic [127:0] key);
    logic [31:0] w [0:43];
    logic [31:0] temp;
    logic [7:0]  rc;
    exp_t        e;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      temp = w[i-1];
      if (i % 4 == 0) begin
        temp = {temp[23:0], temp[31:24]};
        temp = {sb_tab[temp[31:24]], sb_tab[temp[23:16]], sb_tab[temp[15:8]], sb_tab[temp[7:0]]};
        temp ^= {rc, 24'h0};
        rc = xtime(rc);
      end
      w[i] = w[i-4] ^ temp;
    end
    for (int r = 0; r <= 10; r++) begin
      e.idx = 4'(r);
      e.key = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
      sb_q.push_back(e);
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        done_pend = 1'b0;
      end else begin
        check("done", 128'(bus.done), 128'(done_pend));
        done_pend = 1'b0;
        if (bus.key_valid) begin
          if (sb_q.size() == 0) begin
            check("unexpected_valid", 128'(bus.key_valid), 128'(0));
          end else begin
            check("round_idx", 128'(bus.round_idx), 128'(sb_q[0].idx));
            check("round_key", bus.round_key, sb_q[0].key);
            check("busy", 128'(bus.busy), 128'(1));
            if (bus.key_ready) begin
              if (sb_q[0].idx == 4'd10) done_pend = 1'b1;
              void'(sb_q.pop_front());
            end
          end
        end
      end
    end
  end

  // ---------------- ready driver ----------------
  initial begin
    bus.key_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      bus.key_ready = ready_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // ---------------- stimulus helpers (called at posedge+1) ----------------
  task automatic issue_start(input logic [127:0] key);
    push_expected(key);
    bus.start  = 1'b1;
    bus.key_in = key;
    @(posedge clk);
    #1;
    bus.start  = 1'b0;
    bus.key_in = {$urandom(), $urandom(), $urandom(), $urandom()};
  endtask

  task automatic wait_drain(input string name);
    for (int c = 0; c < 400 && sb_q.size() != 0; c++) begin
      @(posedge clk);
      #1;
    end
    if (sb_q.size() != 0) begin
      check({name, "_timeout"}, 128'(sb_q.size()), 128'(0));
      sb_q.delete();
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic wait_idx(input logic [3:0] target);
    int c;
    c = 0;
    while (!(bus.key_valid && bus.round_idx == target) && c < 200) begin
      @(posedge clk);
      #1;
      c++;
    end
    if (c >= 200) check("wait_idx_timeout", 128'(bus.round_idx), 128'(target));
  endtask

  // Cycle-exact run with key_ready held high; ends in the done cycle
  task automatic check_kat(input logic [127:0] key, input logic [127:0] k1,
                           input logic [127:0] k10, input bit use_k10);
    issue_start(key);
    check("kat_valid_c1", 128'(bus.key_valid), 128'(1));
    check("kat_idx_c1", 128'(bus.round_idx), 128'(0));
    check("kat_key0", bus.round_key, key);
    for (int cyc = 2; cyc <= 12; cyc++) begin
      @(posedge clk);
      #1;
      if (cyc == 2) check("kat_key1", bus.round_key, k1);
      if (cyc == 11) begin
        check("kat_idx_c11", 128'(bus.round_idx), 128'(10));
        if (use_k10) check("kat_key10", bus.round_key, k10);
      end
      if (cyc == 12) begin
        check("kat_done_c12", 128'(bus.done), 128'(1));
        check("kat_busy_c12", 128'(bus.busy), 128'(0));
      end
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    bus.start  = 1'b0;
    bus.key_in = '0;
    build_sbox();

    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", 128'(bus.key_valid), 128'(0));
    check("rst_busy", 128'(bus.busy), 128'(0));
    check("rst_done", 128'(bus.done), 128'(0));
    check("rst_key", bus.round_key, 128'(0));
    check("rst_idx", 128'(bus.round_idx), 128'(0));
    rst = 1'b0;
    @(posedge clk);
    #1;

    // FIPS-197 key, ready held high
    check_kat(C_FIPS_KEY, C_FIPS_K1, C_FIPS_K10, 1'b1);
    wait_drain("fips");

    // Same key under random backpressure
    ready_rand = 1'b1;
    issue_start(C_FIPS_KEY);
    wait_drain("fips_stall");

    // Start with a different key mid-expansion must be ignored
    issue_start(C_FIPS_KEY);
    wait_idx(4'd4);
    bus.start  = 1'b1;
    bus.key_in = C_SEQ_KEY;
    @(posedge clk);
    #1;
    bus.start  = 1'b0;
    wait_drain("ignore_start");
    ready_rand = 1'b0;

    // Asynchronous reset mid-expansion
    issue_start(C_FIPS_KEY);
    wait_idx(4'd6);
    #2;
    rst = 1'b1;
    #1;
    sb_q.delete();
    check("arst_valid", 128'(bus.key_valid), 128'(0));
    check("arst_busy", 128'(bus.busy), 128'(0));
    check("arst_done", 128'(bus.done), 128'(0));
    check("arst_key", bus.round_key, 128'(0));
    check("arst_idx", 128'(bus.round_idx), 128'(0));
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    check_kat(C_SEQ_KEY, C_SEQ_K1, C_SEQ_K10, 1'b1);
    wait_drain("seq");

    // All-zero key, then back-to-back start in the done cycle
    check_kat(128'h0, C_ZERO_K1, 128'h0, 1'b0);
    issue_start(128'h0);
    check("b2b_valid", 128'(bus.key_valid), 128'(1));
    check("b2b_idx", 128'(bus.round_idx), 128'(0));
    wait_drain("b2b");

    // Random keys under random backpressure
    ready_rand = 1'b1;
    for (int k = 0; k < 4; k++) begin
      issue_start({$urandom(), $urandom(), $urandom(), $urandom()});
      wait_drain("random");
    end
    ready_rand = 1'b0;

    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Global watchdog
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
